// File: rtl/eprisc_bus_master.sv
// eprisc_bus_master: single-device-at-a-time serial bus master.
// A word of DATA_W bits is exchanged as BEATS beats of LANES bits, MS group
// first, framed by SETUP and HOLD phases. Each phase lasts CLKDIV cycles.
// All outputs are registered. A separate 2-flop path synchronises the device
// interrupt and flags its rising edges.
module eprisc_bus_master #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2,
    parameter int CLKDIV = 4
) (
    input  logic              iBoardClock,
    input  logic              iBoardReset,
    input  logic              iStart,
    input  logic [SEL_W-1:0]  iDevice,
    input  logic [DATA_W-1:0] iTxData,
    output logic              oReady,
    output logic              oDone,
    output logic              oError,
    output logic [DATA_W-1:0] oRxData,
    output logic              oBusClock,
    output logic [SEL_W-1:0]  oBusSelect,
    output logic [LANES-1:0]  oBusMOSI,
    input  logic [LANES-1:0]  iBusMISO,
    input  logic              iBusInterrupt,
    output logic              oIrq,
    output logic              oIrqEdge
);

    localparam int BEATS  = DATA_W / LANES;
    localparam int CNT_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKDIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [DATA_W-1:0]   tx_q;       // beats still to be sent, next one at the top
    logic [DATA_W-1:0]   rx_q;       // receive shift register
    logic [DATA_W-1:0]   rx_data_q;
    logic                ready_q;
    logic                done_q;
    logic                err_q;
    logic                bus_clk_q;
    logic [SEL_W-1:0]    sel_q;      // doubles as the latched device code
    logic [LANES-1:0]    mosi_q;
    logic                sync1_q;
    logic                irq_q;
    logic                irq_edge_q;

    logic                phase_end_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [DATA_W-1:0]   rx_d;
    logic [DATA_W-1:0]   tx_d;

    // Phase timing and shift-register next values.
    always_comb begin
        phase_end_d = (cnt_q == CNT_LAST);
        cnt_d       = phase_end_d ? '0 : (cnt_q + CNT_W'(1));
        rx_d        = (rx_q << LANES) | DATA_W'(iBusMISO);
        tx_d        = tx_q << LANES;
    end

    // Transaction state machine with registered bus and handshake outputs.
    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bus_clk_q <= 1'b0;
            sel_q     <= '0;
            mosi_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        if (iDevice != '0) begin
                            state_q <= ST_SETUP;
                            cnt_q   <= '0;
                            beat_q  <= '0;
                            sel_q   <= iDevice;
                            mosi_q  <= iTxData[DATA_W-1 -: LANES];
                            tx_q    <= iTxData << LANES;
                            rx_q    <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q   <= ST_HIGH;
                        bus_clk_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        rx_q      <= rx_d;
                        bus_clk_q <= 1'b0;
                        if (beat_q == BEAT_LAST) begin
                            state_q <= ST_HOLD;
                        end else begin
                            // Next beat goes out on the first LOW cycle.
                            state_q <= ST_LOW;
                            beat_q  <= beat_q + BEAT_W'(1);
                            mosi_q  <= tx_q[DATA_W-1 -: LANES];
                            tx_q    <= tx_d;
                        end
                    end
                end
                ST_LOW: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q   <= ST_HIGH;
                        bus_clk_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    cnt_q <= cnt_d;
                    if (phase_end_d) begin
                        state_q   <= ST_IDLE;
                        sel_q     <= '0;
                        rx_data_q <= rx_q;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    sel_q     <= '0;
                    bus_clk_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    // Interrupt synchroniser and rising-edge detector, independent of the FSM.
    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) begin
            sync1_q    <= 1'b0;
            irq_q      <= 1'b0;
            irq_edge_q <= 1'b0;
        end else begin
            sync1_q    <= iBusInterrupt;
            irq_q      <= sync1_q;
            irq_edge_q <= sync1_q & ~irq_q;
        end
    end

    assign oReady     = ready_q;
    assign oDone      = done_q;
    assign oError     = err_q;
    assign oRxData    = rx_data_q;
    assign oBusClock  = bus_clk_q;
    assign oBusSelect = sel_q;
    assign oBusMOSI   = mosi_q;
    assign oIrq       = irq_q;
    assign oIrqEdge   = irq_edge_q;

endmodule

// File: tb/tb_eprisc_bus_master.sv
// Scoreboard bench for eprisc_bus_master: a default instance in MISO=MOSI^mask
// loopback and a narrow instance (4 lanes, 16 bits, CLKDIV 1) with fixed MISO.
module tb_eprisc_bus_master;

    localparam int ACT   = 4 * (2 * 4 + 1);   // default: 36 active cycles
    localparam int ACT_S = 1 * (2 * 4 + 1);   // narrow: 9 active cycles

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_in;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // default instance
    logic        start;
    logic [1:0]  dev;
    logic [31:0] txd;
    logic        ready, done, err, bus_clk, irq, irq_edge;
    logic [31:0] rxd;
    logic [1:0]  sel;
    logic [7:0]  mosi, miso, mask;

    // narrow instance
    logic        s_start;
    logic [15:0] s_txd, s_rxd;
    logic        s_ready, s_done, s_err, s_bus_clk, s_irq, s_irq_edge;
    logic [1:0]  s_sel;
    logic [3:0]  s_mosi;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
        logic [1:0]  dev;
        int          start;
    } txn_t;

    txn_t sb_q[$];
    int   err_q[$];
    int   sb_s_q[$];

    assign miso = mosi ^ mask;

    eprisc_bus_master dut (
        .iBoardClock(clk), .iBoardReset(rst_n), .iStart(start), .iDevice(dev),
        .iTxData(txd), .oReady(ready), .oDone(done), .oError(err), .oRxData(rxd),
        .oBusClock(bus_clk), .oBusSelect(sel), .oBusMOSI(mosi), .iBusMISO(miso),
        .iBusInterrupt(irq_in), .oIrq(irq), .oIrqEdge(irq_edge)
    );

    eprisc_bus_master #(.LANES(4), .DATA_W(16), .SEL_W(2), .CLKDIV(1)) dut_s (
        .iBoardClock(clk), .iBoardReset(rst_n), .iStart(s_start), .iDevice(2'd3),
        .iTxData(s_txd), .oReady(s_ready), .oDone(s_done), .oError(s_err),
        .oRxData(s_rxd), .oBusClock(s_bus_clk), .oBusSelect(s_sel), .oBusMOSI(s_mosi),
        .iBusMISO(4'hA), .iBusInterrupt(irq_in), .oIrq(s_irq), .oIrqEdge(s_irq_edge)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Request one transaction from the default instance (caller sits at a negedge).
    task automatic issue(input logic [1:0] d, input logic [31:0] data, input logic [7:0] m);
        wait_ready();
        mask  = m;
        start = 1'b1;
        dev   = d;
        txd   = data;
        if (d != 2'd0) sb_q.push_back('{data, data ^ {4{m}}, d, cyc + 1});
        else           err_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        dev   = 2'($urandom);
        txd   = $urandom;
    endtask

    // Monitor for the default instance.
    int act_cnt = 0, bidx = 0;
    logic pclk = 1'b0;
    always @(negedge clk) begin
        txn_t t;
        logic [31:0] tmp;
        int e;
        if (!rst_n) begin
            act_cnt = 0; bidx = 0; pclk = 1'b0;
        end else begin
            if (bus_clk && !pclk) begin
                if (sb_q.size() == 0) chk("bus_clk_unexpected", 32'd1, 32'd0);
                else begin
                    tmp = sb_q[0].tx << (8 * bidx);
                    chk("mosi_beat", {24'd0, mosi}, {24'd0, tmp[31:24]});
                    chk("bus_select", {30'd0, sel}, {30'd0, sb_q[0].dev});
                end
                bidx++;
            end
            pclk = bus_clk;
            if (sel != 2'd0) act_cnt++;
            if (done) begin
                if (sb_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    t = sb_q.pop_front();
                    chk("rx_data", rxd, t.rx);
                    chk("done_latency", cyc, t.start + ACT);
                    chk("active_cycles", act_cnt, ACT);
                    chk("beat_count", bidx, 4);
                    chk("ready_at_done", {31'd0, ready}, 32'd1);
                    chk("select_at_done", {30'd0, sel}, 32'd0);
                end
                act_cnt = 0; bidx = 0;
            end
            if (err) begin
                if (err_q.size() == 0) chk("error_unexpected", 32'd1, 32'd0);
                else begin
                    e = err_q.pop_front();
                    chk("error_cycle", cyc, e);
                    chk("ready_at_error", {31'd0, ready}, 32'd1);
                    chk("select_at_error", {30'd0, sel}, 32'd0);
                end
            end
        end
    end

    // Monitor for the narrow instance.
    int act_s = 0;
    always @(negedge clk) begin
        int st;
        if (!rst_n) act_s = 0;
        else begin
            if (s_sel != 2'd0) act_s++;
            if (s_done) begin
                if (sb_s_q.size() == 0) chk("s_done_unexpected", 32'd1, 32'd0);
                else begin
                    st = sb_s_q.pop_front();
                    chk("s_rx_data", {16'd0, s_rxd}, 32'h0000AAAA);
                    chk("s_done_latency", cyc, st + ACT_S);
                    chk("s_active_cycles", act_s, ACT_S);
                end
                act_s = 0;
            end
        end
    end

    // Interrupt reference: oIrq is the input as seen two edges ago.
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; end
        else begin h2 = h1; h1 = h0; h0 = irq_in; end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("irq_level", {31'd0, irq}, {31'd0, h1});
            chk("irq_edge", {31'd0, irq_edge}, {31'd0, h1 & ~h2});
        end
    end

    // Random interrupt activity throughout the run.
    initial begin
        irq_in = 1'b0;
        forever begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) irq_in = ~irq_in;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; dev = 2'd0; txd = 32'd0; mask = 8'd0;
        s_start = 1'b0; s_txd = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_outputs", {done, err, bus_clk, irq, irq_edge, sel, mosi}, 32'd0);
        chk("rst_rx", rxd, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);

        issue(2'd1, 32'hDEADBEEF, 8'h00);
        issue(2'd0, 32'h11111111, 8'h00);
        for (int i = 0; i < 12; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Back-to-back: iStart held through the busy period and the oDone cycle.
        wait_ready();
        mask = 8'h00; start = 1'b1; dev = 2'd1; txd = 32'hCAFEF00D;
        sb_q.push_back('{32'hCAFEF00D, 32'hCAFEF00D, 2'd1, cyc + 1});
        @(negedge clk);
        txd = 32'h12345678;
        wait_ready();
        sb_q.push_back('{32'h12345678, 32'h12345678, 2'd1, cyc + 1});
        @(negedge clk);
        start = 1'b0;

        // Narrow instance.
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("s_ready_timeout", 32'd0, 32'd1);
            s_start = 1'b1; s_txd = 16'($urandom);
            sb_s_q.push_back(cyc + 1);
            @(negedge clk);
            s_start = 1'b0;
        end

        // Reset ten cycles into a transfer.
        wait_ready();
        issue(2'd2, $urandom, 8'($urandom));
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete(); err_q.delete(); sb_s_q.delete();
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_bus", {bus_clk, done, sel, mosi}, 32'd0);
        chk("mid_rst_rx", rxd, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("post_rst_rx", rxd, 32'd0);

        issue(2'd3, $urandom, 8'($urandom));

        n = 0;
        while ((sb_q.size() != 0 || sb_s_q.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
